// File: rtl/dmem_bridge.sv
// dmem_bridge: turns the core's single-cycle data-access port into one
// valid/ready bus transaction per access. The core is stalled until the
// response returns. Each access is bounded by a timeout, and the first
// bus error or timeout since the last clear is recorded.
module dmem_bridge #(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              acs_en,
  input  logic              acs_wr,
  input  logic [XLEN/8-1:0] acs_bytes,
  input  logic [XLEN-1:0]   acs_addr,
  input  logic [XLEN-1:0]   acs_wdata,
  output logic [XLEN-1:0]   acs_rdata,
  output logic              stall,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic              bus_req_wr,
  output logic [XLEN-1:0]   bus_req_addr,
  output logic [XLEN/8-1:0] bus_req_strb,
  output logic [XLEN-1:0]   bus_req_wdata,
  input  logic              bus_rsp_valid,
  input  logic [XLEN-1:0]   bus_rsp_rdata,
  input  logic              bus_rsp_err,
  input  logic              err_clr,
  output logic              err_flag,
  output logic [XLEN-1:0]   err_addr
);

  localparam int SW = XLEN / 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic              wr_q;
  logic [XLEN-1:0]   addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [SW-1:0]     strb_q;
  logic [CNT_W-1:0]  cnt;

  logic              busy;
  logic              capture;
  logic              rsp_take;
  logic              timeout_hit;
  logic              err_event;

  // A new access is accepted only from IDLE. An acs_en that is still high in
  // DONE is the access just completed, so it is not accepted again.
  assign capture  = (state == S_IDLE) && acs_en;
  assign busy     = (state == S_REQ) || (state == S_RESP);
  assign rsp_take = (state == S_RESP) && bus_rsp_valid;

  // The counter has already counted this cycle, so TIMEOUT-1 marks the last
  // allowed cycle. A response that lands on that same cycle still wins.
  assign timeout_hit = busy && (cnt == CNT_W'(TIMEOUT - 1)) && !rsp_take;
  assign err_event   = (rsp_take && bus_rsp_err) || timeout_hit;

  assign bus_req_wr    = wr_q;
  assign bus_req_addr  = addr_q;
  assign bus_req_strb  = strb_q;
  assign bus_req_wdata = wdata_q;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first, so that paths which do not assign state_nxt cannot
    // infer a latch.
    state_nxt = state;
    unique case (state)
      S_IDLE: if (acs_en) state_nxt = S_REQ;
      S_REQ: begin
        if (timeout_hit)        state_nxt = S_DONE;
        else if (bus_req_ready) state_nxt = S_RESP;
      end
      S_RESP: if (rsp_take || timeout_hit) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode: stall follows acs_en in IDLE and is released for the DONE cycle.
  always_comb begin
    stall         = 1'b0;
    bus_req_valid = 1'b0;
    unique case (state)
      S_IDLE:  stall = acs_en;
      S_REQ: begin
        stall         = 1'b1;
        bus_req_valid = 1'b1;
      end
      S_RESP:  stall = 1'b1;
      S_DONE:  stall = 1'b0;
      default: stall = 1'b0;
    endcase
  end

  // Request capture and timeout counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      cnt     <= '0;
    end else if (capture) begin
      wr_q    <= acs_wr;
      addr_q  <= acs_addr;
      wdata_q <= acs_wdata;
      strb_q  <= acs_bytes;
      cnt     <= '0;
    end else if (busy) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Load-data return: stores return zero, and a timeout returns all ones.
  always_ff @(posedge clk) begin
    if (rst)              acs_rdata <= '0;
    else if (rsp_take)    acs_rdata <= wr_q ? '0 : bus_rsp_rdata;
    else if (timeout_hit) acs_rdata <= '1;
  end

  // Sticky error record. A new error beats a simultaneous clear and counts
  // as the first error after that clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_flag <= 1'b0;
      err_addr <= '0;
    end else if (err_event) begin
      err_flag <= 1'b1;
      if (!err_flag || err_clr) err_addr <= addr_q;
    end else if (err_clr) begin
      err_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed testbench for dmem_bridge (TIMEOUT=16). Inputs are driven at the
// falling edge, and outputs are sampled 1 time unit later.
module tb_dmem_bridge;

  localparam int XLEN = 64;
  localparam int SW   = XLEN / 8;
  localparam int TO   = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              acs_en;
  logic              acs_wr;
  logic [SW-1:0]     acs_bytes;
  logic [XLEN-1:0]   acs_addr;
  logic [XLEN-1:0]   acs_wdata;
  logic [XLEN-1:0]   acs_rdata;
  logic              stall;
  logic              bus_req_valid;
  logic              bus_req_ready;
  logic              bus_req_wr;
  logic [XLEN-1:0]   bus_req_addr;
  logic [SW-1:0]     bus_req_strb;
  logic [XLEN-1:0]   bus_req_wdata;
  logic              bus_rsp_valid;
  logic [XLEN-1:0]   bus_rsp_rdata;
  logic              bus_rsp_err;
  logic              err_clr;
  logic              err_flag;
  logic [XLEN-1:0]   err_addr;

  int   n_vec = 0;
  int   n_err = 0;
  int   stall_cycles;
  int   handshakes;
  int   field_bad;
  int   hs_total;
  logic done_seen;

  dmem_bridge #(.XLEN(XLEN), .TIMEOUT(TO), .CNT_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .acs_en        (acs_en),
    .acs_wr        (acs_wr),
    .acs_bytes     (acs_bytes),
    .acs_addr      (acs_addr),
    .acs_wdata     (acs_wdata),
    .acs_rdata     (acs_rdata),
    .stall         (stall),
    .bus_req_valid (bus_req_valid),
    .bus_req_ready (bus_req_ready),
    .bus_req_wr    (bus_req_wr),
    .bus_req_addr  (bus_req_addr),
    .bus_req_strb  (bus_req_strb),
    .bus_req_wdata (bus_req_wdata),
    .bus_rsp_valid (bus_rsp_valid),
    .bus_rsp_rdata (bus_rsp_rdata),
    .bus_rsp_err   (bus_rsp_err),
    .err_clr       (err_clr),
    .err_flag      (err_flag),
    .err_addr      (err_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs one access from an IDLE falling edge. The bus raises ready after
  // ready_delay cycles of valid, and responds rsp_delay cycles after the
  // handshake (a negative rsp_delay means it never responds). The task
  // returns at the DONE cycle, with acs_en still high.
  task automatic run_access(input logic wr, input logic [63:0] addr, input logic [7:0] strb,
                            input logic [63:0] wdata, input int ready_delay, input int rsp_delay,
                            input logic [63:0] rdata, input logic rerr);
    int   req_wait = 0;
    int   rsp_wait = 0;
    logic accepted = 1'b0;
    stall_cycles = 0;
    handshakes   = 0;
    field_bad    = 0;
    done_seen    = 1'b0;
    acs_en        = 1'b1;
    acs_wr        = wr;
    acs_addr      = addr;
    acs_bytes     = strb;
    acs_wdata     = wdata;
    bus_rsp_rdata = rdata;
    bus_rsp_err   = rerr;
    for (int c = 0; c < 64 && !done_seen; c++) begin
      #1;
      bus_rsp_valid = 1'b0;
      bus_req_ready = 1'b0;
      if (!stall) begin
        done_seen = 1'b1;
      end else begin
        stall_cycles++;
        if (accepted) begin
          bus_rsp_valid = (rsp_wait == rsp_delay);
          rsp_wait++;
        end
        if (bus_req_valid) begin
          if (bus_req_wr !== wr || bus_req_addr !== addr || bus_req_strb !== strb ||
              bus_req_wdata !== wdata) field_bad++;
          bus_req_ready = (req_wait >= ready_delay);
          req_wait++;
          if (bus_req_ready) begin
            handshakes++;
            accepted = 1'b1;
          end
        end
        @(negedge clk);
      end
    end
    bus_rsp_valid = 1'b0;
    bus_req_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; acs_en = 1'b0; acs_wr = 1'b0; acs_bytes = '0; acs_addr = '0; acs_wdata = '0;
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_rdata = '0; bus_rsp_err = 1'b0;
    err_clr = 1'b0;
    hs_total = 0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", stall, 1'b0);
    check("rst_valid", bus_req_valid, 1'b0);
    check("rst_rdata", acs_rdata, 64'h0);
    check("rst_errflag", err_flag, 1'b0);
    check("rst_erraddr", err_addr, 64'h0);
    rst = 1'b0;
    @(negedge clk);

    // 1: minimum-latency load
    run_access(1'b0, 64'h1000, 8'hFF, 64'h0, 0, 0, 64'h1122334455667788, 1'b0);
    check("t1_done", done_seen, 1'b1);
    check("t1_stall_cycles", stall_cycles, 3);
    check("t1_handshakes", handshakes, 1);
    check("t1_fields", field_bad, 0);
    check("t1_rdata", acs_rdata, 64'h1122334455667788);
    check("t1_done_valid", bus_req_valid, 1'b0);
    acs_en = 1'b0;
    @(negedge clk);
    #1;
    check("t1_idle_stall", stall, 1'b0);
    check("t1_rdata_held", acs_rdata, 64'h1122334455667788);
    @(negedge clk);

    // 2: store with ready held low for 5 cycles
    run_access(1'b1, 64'h80000010, 8'h0F, 64'hDEADBEEF, 5, 0, 64'hFFFF0000AAAA5555, 1'b0);
    check("t2_stall_cycles", stall_cycles, 8);
    check("t2_handshakes", handshakes, 1);
    check("t2_fields_stable", field_bad, 0);
    check("t2_rdata_zero", acs_rdata, 64'h0);
    check("t2_errflag", err_flag, 1'b0);
    acs_en = 1'b0;
    @(negedge clk);

    // 4: error recording, first error address kept, clear, then re-record
    run_access(1'b0, 64'h100, 8'hFF, 64'h0, 0, 0, 64'hA5, 1'b1);
    check("t4_errflag1", err_flag, 1'b1);
    check("t4_erraddr1", err_addr, 64'h100);
    check("t4_rdata", acs_rdata, 64'hA5);
    acs_en = 1'b0;
    @(negedge clk);
    run_access(1'b0, 64'h200, 8'hFF, 64'h0, 2, 1, 64'h5A, 1'b1);
    check("t4_stall_cycles2", stall_cycles, 6);
    check("t4_erraddr2", err_addr, 64'h100);
    acs_en = 1'b0;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    #1;
    check("t4_clr", err_flag, 1'b0);
    @(negedge clk);
    run_access(1'b0, 64'h300, 8'hFF, 64'h0, 0, 0, 64'h77, 1'b1);
    check("t4_errflag3", err_flag, 1'b1);
    check("t4_erraddr3", err_addr, 64'h300);
    acs_en = 1'b0;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    #1;
    check("t4_clr2", err_flag, 1'b0);
    @(negedge clk);

    // 3: bus never responds, so the access times out after 16 cycles
    run_access(1'b0, 64'h40000008, 8'hFF, 64'h0, 0, -1, 64'h1234, 1'b0);
    check("t3_done", done_seen, 1'b1);
    check("t3_stall_cycles", stall_cycles, TO + 1);
    check("t3_handshakes", handshakes, 1);
    check("t3_rdata_ones", acs_rdata, 64'hFFFFFFFFFFFFFFFF);
    check("t3_errflag", err_flag, 1'b1);
    check("t3_erraddr", err_addr, 64'h40000008);
    acs_en = 1'b0;
    @(negedge clk);

    // 5: reset during RESP, then a late response that must be discarded
    acs_en = 1'b1; acs_wr = 1'b0; acs_addr = 64'h500; acs_bytes = 8'hFF; bus_req_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("t5_in_resp_stall", stall, 1'b1);
    check("t5_in_resp_valid", bus_req_valid, 1'b0);
    rst = 1'b1;
    bus_req_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    acs_en = 1'b0;
    #1;
    check("t5_rst_stall", stall, 1'b0);
    check("t5_rst_errflag", err_flag, 1'b0);
    bus_rsp_valid = 1'b1;
    bus_rsp_rdata = 64'hBAD0BAD0BAD0BAD0;
    @(negedge clk);
    bus_rsp_valid = 1'b0;
    #1;
    check("t5_late_rsp_ignored", acs_rdata, 64'h0);
    check("t5_late_rsp_stall", stall, 1'b0);
    @(negedge clk);
    run_access(1'b0, 64'h600, 8'hFF, 64'h0, 0, 0, 64'hCAFEF00D, 1'b0);
    check("t5_next_stall_cycles", stall_cycles, 3);
    check("t5_next_rdata", acs_rdata, 64'hCAFEF00D);
    acs_en = 1'b0;
    @(negedge clk);

    // 6: back-to-back loads with acs_en held high through DONE
    run_access(1'b0, 64'h700, 8'hFF, 64'h0, 0, 0, 64'hAAAA, 1'b0);
    hs_total = handshakes;
    check("t6_rdata1", acs_rdata, 64'hAAAA);
    check("t6_done_no_req", bus_req_valid, 1'b0);
    @(negedge clk);
    #1;
    check("t6_idle_stall", stall, 1'b1);
    check("t6_idle_no_req", bus_req_valid, 1'b0);
    run_access(1'b0, 64'h708, 8'hFF, 64'h0, 0, 0, 64'hBBBB, 1'b0);
    hs_total += handshakes;
    check("t6_stall_cycles2", stall_cycles, 3);
    check("t6_fields2", field_bad, 0);
    check("t6_rdata2", acs_rdata, 64'hBBBB);
    check("t6_handshakes_total", hs_total, 2);
    acs_en = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
